// File: rtl/io_read_sequencer.sv
// io_read_sequencer
//   Turns a CPU I/O read request (ior + io_addr) into a one-hot req/ack
//   handshake with one of four readable peripherals. It stalls the CPU while
//   the read is in flight, then returns a 16-bit result with a one-cycle valid.
//
// Optional feature: define IOREAD_TIMEOUT_EN to abort a read that sees no
// dev_ack within TIMEOUT_CYC request cycles. An aborted read returns 16'hFFFF
// with rd_err set. Without the macro, REQ waits indefinitely and no counter
// is built.
//
// Parameters
//   TIMEOUT_CYC  request cycles allowed before abort (timeout build only)
//   CNT_W        wait counter width, 2**CNT_W must exceed TIMEOUT_CYC
//
// Ports
//   clock     in   1   system clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   ior       in   1   I/O read request level, held while rd_stall=1
//   io_addr   in   8   low byte of the I/O address, [7:4] selects the device
//   dev_req   out  4   one-hot request: [0] switch [1] keyboard [2] timer [3] PWM
//   dev_ack   in   4   per-device acknowledge, dev_data valid in the same cycle
//   dev_data  in  64   device i drives bits [16i+15:16i]
//   rd_data   out 16   read result, held until the next accepted read
//   rd_valid  out  1   one-cycle pulse marking a completed read
//   rd_stall  out  1   combinational CPU stall
//   rd_err    out  1   last read was unmapped or timed out (sticky)
module io_read_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ior,
  input  logic [7:0]  io_addr,
  output logic [3:0]  dev_req,
  input  logic [3:0]  dev_ack,
  input  logic [63:0] dev_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_stall,
  output logic        rd_err
);

  localparam int unsigned NUM_DEV = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SEL_W   = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Elaboration-time sanity check on the counter width.
  if ((2 ** CNT_W) <= TIMEOUT_CYC || TIMEOUT_CYC == 0) begin : g_cnt_w_check
    $error("io_read_sequencer: CNT_W too small or TIMEOUT_CYC zero");
  end

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_DEV-1:0] dev_req_q, dev_req_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_err_q, rd_err_d;

`ifdef IOREAD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Low nibble of the address is don't-care for device selection.
  logic unused_addr_lo;
  assign unused_addr_lo = ^io_addr[3:0];

  // Address decode on io_addr[7:4].
  logic             dec_hit_c;
  logic [SEL_W-1:0] dec_sel_c;
  always_comb begin
    dec_hit_c = 1'b1;
    dec_sel_c = '0;
    case (io_addr[7:4])
      4'h7:    dec_sel_c = 2'd0;
      4'h1:    dec_sel_c = 2'd1;
      4'h2:    dec_sel_c = 2'd2;
      4'h3:    dec_sel_c = 2'd3;
      default: dec_hit_c = 1'b0;
    endcase
  end

  // Ack and data of the latched device only; other acks are ignored.
  logic              ack_sel_c;
  logic [DATA_W-1:0] data_sel_c;
  always_comb begin
    ack_sel_c  = 1'b0;
    data_sel_c = '0;
    case (sel_q)
      2'd0: begin ack_sel_c = dev_ack[0]; data_sel_c = dev_data[15:0];  end
      2'd1: begin ack_sel_c = dev_ack[1]; data_sel_c = dev_data[31:16]; end
      2'd2: begin ack_sel_c = dev_ack[2]; data_sel_c = dev_data[47:32]; end
      default: begin ack_sel_c = dev_ack[3]; data_sel_c = dev_data[63:48]; end
    endcase
  end

  // State register and all datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      dev_req_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
`ifdef IOREAD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dev_req_q  <= dev_req_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
`ifdef IOREAD_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state and registered-output logic; rd_valid_d is set on entry to DONE
  // so the registered pulse lines up exactly with the DONE cycle.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dev_req_d  = dev_req_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = rd_err_q;
`ifdef IOREAD_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ior) begin
          sel_d    = dec_sel_c;
          rd_err_d = 1'b0;
`ifdef IOREAD_TIMEOUT_EN
          cnt_d    = '0;
`endif
          if (dec_hit_c) begin
            state_d   = ST_REQ;
            dev_req_d = NUM_DEV'(1) << dec_sel_c;
          end else begin
            state_d    = ST_DONE;
            rd_data_d  = '0;
            rd_err_d   = 1'b1;
            rd_valid_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // An ack coinciding with the last timeout cycle takes priority.
        if (ack_sel_c) begin
          rd_data_d  = data_sel_c;
          dev_req_d  = '0;
          state_d    = ST_DONE;
          rd_valid_d = 1'b1;
        end else begin
`ifdef IOREAD_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            dev_req_d  = '0;
            rd_data_d  = 16'hFFFF;
            rd_err_d   = 1'b1;
            state_d    = ST_DONE;
            rd_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        dev_req_d = '0;
      end
    endcase
  end

  assign dev_req  = dev_req_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

  // Stall is combinational so the CPU freezes in the same cycle ior rises.
  assign rd_stall = (state_q == ST_REQ) || ((state_q == ST_IDLE) && ior);

endmodule

// File: tb/tb_io_read_sequencer.sv
// Directed bench for io_read_sequencer with a scoreboard of expected results.
module tb_io_read_sequencer;

  localparam int unsigned TMO = 16;

  logic        clock;
  logic        reset;
  logic        ior;
  logic [7:0]  io_addr;
  logic [3:0]  dev_req;
  logic [3:0]  dev_ack;
  logic [63:0] dev_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_stall;
  logic        rd_err;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  io_read_sequencer #(.TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .ior      (ior),
    .io_addr  (io_addr),
    .dev_req  (dev_req),
    .dev_ack  (dev_ack),
    .dev_data (dev_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_stall (rd_stall),
    .rd_err   (rd_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (reset === 1'b1 && rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 64'(rd_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rd_data", 64'(rd_data), 64'(e.data));
        check("sb_rd_err", 64'(rd_err), 64'(e.err));
      end
    end
  end

  initial begin
    reset    = 1'b0;
    ior      = 1'b1;
    io_addr  = 8'h70;
    dev_ack  = 4'b0000;
    dev_data = 64'h0;

    // Reset held for three cycles with ior asserted.
    repeat (3) @(negedge clock);
    check("rst_dev_req", 64'(dev_req), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_err", 64'(rd_err), 64'(0));

    // Release; switch read with immediate ack.
    reset = 1'b1;
    dev_ack = 4'b0001;
    dev_data[15:0] = 16'hA5A5;
    push(16'hA5A5, 1'b0);
    #1;
    check("sw_stall_idle", 64'(rd_stall), 64'(1));
    @(negedge clock);
    check("sw_dev_req", 64'(dev_req), 64'(4'b0001));
    check("sw_stall_req", 64'(rd_stall), 64'(1));
    check("sw_valid_early", 64'(rd_valid), 64'(0));
    @(negedge clock);
    check("sw_valid", 64'(rd_valid), 64'(1));
    check("sw_data", 64'(rd_data), 64'(16'hA5A5));
    check("sw_err", 64'(rd_err), 64'(0));
    check("sw_stall_done", 64'(rd_stall), 64'(0));
    check("sw_req_done", 64'(dev_req), 64'(0));
    ior = 1'b0;
    dev_ack = 4'b0000;
    @(negedge clock);
    check("sw_valid_drop", 64'(rd_valid), 64'(0));
    check("sw_data_hold", 64'(rd_data), 64'(16'hA5A5));

    // Keyboard read, ack on the sixth request cycle; address change in REQ ignored.
    ior = 1'b1;
    io_addr = 8'h1F;
    dev_data[31:16] = 16'h001C;
    push(16'h001C, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      check("kb_dev_req", 64'(dev_req), 64'(4'b0010));
      check("kb_stall", 64'(rd_stall), 64'(1));
      check("kb_valid_early", 64'(rd_valid), 64'(0));
      if (i == 2) io_addr = 8'h20;
      if (i == 6) dev_ack = 4'b0010;
    end
    @(negedge clock);
    check("kb_valid", 64'(rd_valid), 64'(1));
    check("kb_data", 64'(rd_data), 64'(16'h001C));
    ior = 1'b0;
    dev_ack = 4'b0000;
    @(negedge clock);

    // Unmapped read, then a timer read clears the sticky error on accept.
    ior = 1'b1;
    io_addr = 8'hC0;
    push(16'h0000, 1'b1);
    @(negedge clock);
    check("um_valid", 64'(rd_valid), 64'(1));
    check("um_data", 64'(rd_data), 64'(0));
    check("um_err", 64'(rd_err), 64'(1));
    check("um_dev_req", 64'(dev_req), 64'(0));
    check("um_stall", 64'(rd_stall), 64'(0));
    ior = 1'b0;
    @(negedge clock);
    check("um_err_sticky", 64'(rd_err), 64'(1));
    check("um_valid_drop", 64'(rd_valid), 64'(0));
    ior = 1'b1;
    io_addr = 8'h20;
    dev_data[47:32] = 16'h1234;
    push(16'h1234, 1'b0);
    @(negedge clock);
    check("tm_err_clear", 64'(rd_err), 64'(0));
    check("tm_dev_req", 64'(dev_req), 64'(4'b0100));
    dev_ack = 4'b0100;
    @(negedge clock);
    check("tm_valid", 64'(rd_valid), 64'(1));
    ior = 1'b0;
    dev_ack = 4'b0000;
    @(negedge clock);

`ifdef IOREAD_TIMEOUT_EN
    // PWM read with no ack times out; then the same read acked on the last cycle.
    ior = 1'b1;
    io_addr = 8'h30;
    push(16'hFFFF, 1'b1);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clock);
      check("to_dev_req", 64'(dev_req), 64'(4'b1000));
      check("to_valid_early", 64'(rd_valid), 64'(0));
    end
    @(negedge clock);
    check("to_valid", 64'(rd_valid), 64'(1));
    check("to_data", 64'(rd_data), 64'(16'hFFFF));
    check("to_err", 64'(rd_err), 64'(1));
    check("to_dev_req_drop", 64'(dev_req), 64'(0));
    ior = 1'b0;
    @(negedge clock);
    ior = 1'b1;
    dev_data[63:48] = 16'h7777;
    push(16'h7777, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clock);
      check("ta_dev_req", 64'(dev_req), 64'(4'b1000));
      if (i == TMO) dev_ack = 4'b1000;
    end
    @(negedge clock);
    check("ta_valid", 64'(rd_valid), 64'(1));
    check("ta_err", 64'(rd_err), 64'(0));
    ior = 1'b0;
    dev_ack = 4'b0000;
    @(negedge clock);
`else
    // Without the timeout the PWM read waits well past 16 cycles for its ack.
    ior = 1'b1;
    io_addr = 8'h30;
    dev_data[63:48] = 16'h7777;
    push(16'h7777, 1'b0);
    for (int i = 1; i <= TMO + 4; i++) begin
      @(negedge clock);
      check("nt_dev_req", 64'(dev_req), 64'(4'b1000));
      check("nt_valid_early", 64'(rd_valid), 64'(0));
      if (i == TMO + 4) dev_ack = 4'b1000;
    end
    @(negedge clock);
    check("nt_valid", 64'(rd_valid), 64'(1));
    check("nt_err", 64'(rd_err), 64'(0));
    ior = 1'b0;
    dev_ack = 4'b0000;
    @(negedge clock);
`endif

    // Back-to-back: switch then timer with ior held through DONE.
    ior = 1'b1;
    io_addr = 8'h70;
    dev_data[15:0] = 16'h5A01;
    dev_ack = 4'b0001;
    push(16'h5A01, 1'b0);
    @(negedge clock);
    check("bb1_dev_req", 64'(dev_req), 64'(4'b0001));
    @(negedge clock);
    check("bb1_valid", 64'(rd_valid), 64'(1));
    io_addr = 8'h20;
    dev_ack = 4'b0000;
    dev_data[47:32] = 16'h0BEE;
    push(16'h0BEE, 1'b0);
    @(negedge clock);
    check("bb_idle_stall", 64'(rd_stall), 64'(1));
    check("bb_idle_valid", 64'(rd_valid), 64'(0));
    @(negedge clock);
    check("bb2_dev_req", 64'(dev_req), 64'(4'b0100));
    dev_ack = 4'b0010;
    dev_data[31:16] = 16'hDEAD;
    @(negedge clock);
    check("bb2_spurious_req", 64'(dev_req), 64'(4'b0100));
    check("bb2_spurious_valid", 64'(rd_valid), 64'(0));
    dev_ack = 4'b0100;
    @(negedge clock);
    check("bb2_valid", 64'(rd_valid), 64'(1));
    check("bb2_data", 64'(rd_data), 64'(16'h0BEE));
    ior = 1'b0;
    dev_ack = 4'b0000;
    @(negedge clock);

    // Asynchronous reset between edges while in REQ.
    ior = 1'b1;
    io_addr = 8'h10;
    @(negedge clock);
    check("ar_dev_req_pre", 64'(dev_req), 64'(4'b0010));
    #2;
    reset = 1'b0;
    #1;
    check("ar_dev_req_async", 64'(dev_req), 64'(0));
    check("ar_valid_async", 64'(rd_valid), 64'(0));
    ior = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("ar_dev_req_idle", 64'(dev_req), 64'(0));
    check("ar_valid_idle", 64'(rd_valid), 64'(0));
    check("ar_stall_idle", 64'(rd_stall), 64'(0));

    // A fresh switch read after reset proves the FSM is back in IDLE.
    ior = 1'b1;
    io_addr = 8'h7C;
    dev_data[15:0] = 16'h0F0F;
    dev_ack = 4'b0001;
    push(16'h0F0F, 1'b0);
    @(negedge clock);
    check("pr_dev_req", 64'(dev_req), 64'(4'b0001));
    @(negedge clock);
    check("pr_valid", 64'(rd_valid), 64'(1));
    ior = 1'b0;
    dev_ack = 4'b0000;
    repeat (2) @(negedge clock);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
